// File: rtl/tcs_color_classifier.sv
// TCS3200 colour classifier: steps the S2/S3 filter through red, green and
// blue, counts synchronised sensor edges in a fixed gate window per filter,
// then classifies the three counts into an RGBY symbol.
`timescale 1ns/1ps
module tcs_color_classifier #(
   parameter int SETTLE_CYCLES = 100,
   parameter int GATE_CYCLES   = 1000,
   parameter int MARGIN        = 16,
   parameter int MIN_COUNT     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startDetection,
   input  logic       frequencyFromColorSensor,
   output logic [1:0] colorSelect,
   output logic       detectionComplete,
   output logic [1:0] color,
   output logic       colorValid,
   output logic [7:0] freqCount,
   output logic [7:0] redCount,
   output logic [7:0] greenCount,
   output logic [7:0] blueCount,
   output logic       busy
);

   localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
   localparam logic [8:0]    MARGIN9     = 9'(MARGIN);
   localparam logic [7:0]    MIN8        = 8'(MIN_COUNT);

   // channel index: 0 = red, 1 = green, 2 = blue
   localparam logic [1:0] CH_RED   = 2'd0;
   localparam logic [1:0] CH_GREEN = 2'd1;
   localparam logic [1:0] CH_BLUE  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_GATE     = 3'd2,
      ST_CLASSIFY = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t      state_r, state_s;
   logic [1:0]  ch_r, ch_s;
   logic [TW-1:0] timer_r;
   logic [2:0]  sync_r;
   logic        start_r;
   logic [7:0]  count_r, count_inc_s;
   logic [7:0]  wr_r, wg_r, wb_r;
   logic        edge_s;
   logic [1:0]  color_select_r, color_r, cls_color_s;
   logic        done_r, valid_r, busy_r, cls_valid_s, yellow_s;
   logic [7:0]  freq_r, red_r, green_r, blue_r, cls_freq_s;
   logic [8:0]  r9_s, g9_s, b9_s, diff_rg_s;

   // TCS3200 {S2,S3} code for a channel; clear filter when not measuring
   function automatic logic [1:0] sel_for(input logic [1:0] ch);
      logic [1:0] sel;
      case (ch)
         CH_RED:   sel = 2'b00;
         CH_GREEN: sel = 2'b11;
         CH_BLUE:  sel = 2'b01;
         default:  sel = 2'b10;
      endcase
      return sel;
   endfunction

   assign edge_s      = sync_r[1] & ~sync_r[2];
   assign count_inc_s = (edge_s && (count_r != 8'hFF)) ? (count_r + 8'd1) : count_r;

   // Next-state and next-channel logic of the measurement sequencer
   always_comb begin
      state_s = state_r;
      ch_s    = ch_r;
      case (state_r)
         ST_IDLE: begin
            if (start_r) begin
               state_s = ST_SETTLE;
               ch_s    = CH_RED;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (timer_r == SETTLE_LAST) state_s = ST_GATE;
            else                        state_s = ST_SETTLE;
         end
         ST_GATE: begin
            if (timer_r == GATE_LAST) begin
               if (ch_r == CH_BLUE) begin
                  state_s = ST_CLASSIFY;
               end else begin
                  state_s = ST_SETTLE;
                  ch_s    = ch_r + 2'd1;
               end
            end else begin
               state_s = ST_GATE;
            end
         end
         ST_CLASSIFY: state_s = ST_DONE;
         ST_DONE:     state_s = ST_IDLE;
         default:     state_s = ST_IDLE;
      endcase
   end

   // Sequencer state and channel registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         ch_r    <= CH_RED;
      end else begin
         state_r <= state_s;
         ch_r    <= ch_s;
      end
   end

   // Input synchroniser, start capture (IDLE only), dwell timer and edge counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r  <= 3'b000;
         start_r <= 1'b0;
         timer_r <= '0;
         count_r <= 8'd0;
         wr_r    <= 8'd0;
         wg_r    <= 8'd0;
         wb_r    <= 8'd0;
      end else begin
         sync_r  <= {sync_r[1:0], frequencyFromColorSensor};
         start_r <= startDetection & (state_r == ST_IDLE);
         if ((state_s != state_r) || ((state_r != ST_SETTLE) && (state_r != ST_GATE))) begin
            timer_r <= '0;
         end else begin
            timer_r <= timer_r + TW'(1);
         end
         if (state_r == ST_GATE) count_r <= count_inc_s;
         else                    count_r <= 8'd0;
         if ((state_r == ST_GATE) && (timer_r == GATE_LAST)) begin
            case (ch_r)
               CH_RED:   wr_r <= count_inc_s;
               CH_GREEN: wg_r <= count_inc_s;
               CH_BLUE:  wb_r <= count_inc_s;
               default:  wr_r <= wr_r;
            endcase
         end else begin
            wr_r <= wr_r;
         end
      end
   end

   // Classification of the three working counts (9-bit unsigned compares)
   always_comb begin
      r9_s        = {1'b0, wr_r};
      g9_s        = {1'b0, wg_r};
      b9_s        = {1'b0, wb_r};
      diff_rg_s   = (r9_s >= g9_s) ? (r9_s - g9_s) : (g9_s - r9_s);
      yellow_s    = (r9_s >= (b9_s + MARGIN9)) && (g9_s >= (b9_s + MARGIN9)) && (diff_rg_s <= MARGIN9);
      cls_color_s = 2'd2;
      cls_freq_s  = wb_r;
      if (yellow_s) begin
         cls_color_s = 2'd3;
         cls_freq_s  = (wr_r >= wg_r) ? wr_r : wg_r;
      end else if ((wr_r >= wg_r) && (wr_r >= wb_r)) begin
         cls_color_s = 2'd0;
         cls_freq_s  = wr_r;
      end else if (wg_r >= wb_r) begin
         cls_color_s = 2'd1;
         cls_freq_s  = wg_r;
      end else begin
         cls_color_s = 2'd2;
         cls_freq_s  = wb_r;
      end
      cls_valid_s = (cls_freq_s >= MIN8);
   end

   // Registered outputs: filter select, busy, completion pulse and results held between runs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         color_select_r <= 2'b10;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         color_r        <= 2'd0;
         valid_r        <= 1'b0;
         freq_r         <= 8'd0;
         red_r          <= 8'd0;
         green_r        <= 8'd0;
         blue_r         <= 8'd0;
      end else begin
         if ((state_s == ST_SETTLE) || (state_s == ST_GATE)) color_select_r <= sel_for(ch_s);
         else                                                 color_select_r <= 2'b10;
         busy_r <= (state_s != ST_IDLE);
         done_r <= (state_r == ST_CLASSIFY);
         if (state_r == ST_CLASSIFY) begin
            color_r <= cls_color_s;
            valid_r <= cls_valid_s;
            freq_r  <= cls_freq_s;
            red_r   <= wr_r;
            green_r <= wg_r;
            blue_r  <= wb_r;
         end else begin
            color_r <= color_r;
         end
      end
   end

   assign colorSelect       = color_select_r;
   assign busy              = busy_r;
   assign detectionComplete = done_r;
   assign color             = color_r;
   assign colorValid        = valid_r;
   assign freqCount         = freq_r;
   assign redCount          = red_r;
   assign greenCount        = green_r;
   assign blueCount         = blue_r;

endmodule
